// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel LED driver (off/on/blink/pwm/burst) sharing
// one prescaled tick and one free-running PWM counter.
module led_ctrl #(
   parameter int CH      = 2,
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int VAL_W   = 16,
   parameter int PWM_W   = 8,
   parameter int CW      = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CW-1:0]    cfg_ch,
   input  logic [2:0]       cfg_mode,
   input  logic [VAL_W-1:0] cfg_val,
   input  logic [7:0]       cfg_cnt,
   output logic [CH-1:0]    led,
   output logic [CH-1:0]    busy,
   output logic [CH-1:0]    done
);

   localparam int PRESC = CLK_HZ / TICK_HZ;
   localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

   if (PRESC < 1) begin : g_bad_presc
      $error("led_ctrl: CLK_HZ/TICK_HZ must be >= 1");
   end
   if (PWM_W > VAL_W) begin : g_bad_pwm
      $error("led_ctrl: PWM_W must not exceed VAL_W");
   end

   typedef enum logic [2:0] {
      M_OFF,
      M_ON,
      M_BLINK,
      M_PWM,
      M_BURST
   } mode_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_ON,
      B_OFF
   } bst_t;

   logic [PW-1:0]    presc_q;
   logic             tick;
   logic [PWM_W-1:0] pwm_q;
   logic             ch_ok;
   logic             wr_pwm_on;
   mode_t            wr_mode;

   assign tick = (presc_q == PW'(PRESC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         pwm_q   <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + PW'(1);
         pwm_q   <= pwm_q + PWM_W'(1);
      end
   end

   // Extra bit so channel numbers beyond CH can be rejected.
   assign ch_ok     = ({1'b0, cfg_ch} < (CW + 1)'(CH));
   assign wr_pwm_on = (pwm_q < cfg_val[PWM_W-1:0]);

   always_comb begin
      wr_mode = M_OFF;
      unique case (cfg_mode)
         3'd1:    wr_mode = M_ON;
         3'd2:    wr_mode = M_BLINK;
         3'd3:    wr_mode = M_PWM;
         3'd4:    wr_mode = M_BURST;
         default: wr_mode = M_OFF;
      endcase
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      mode_t            mode_q, mode_d;
      bst_t             bst_q, bst_d;
      logic [VAL_W-1:0] hval_q, hval_d;
      logic [VAL_W-1:0] ph_q, ph_d;
      logic [VAL_W-1:0] h_last;
      logic [PWM_W-1:0] duty_q, duty_d;
      logic [7:0]       rem_q, rem_d;
      logic             led_q, led_d;
      logic             busy_q, busy_d;
      logic             done_q, done_d;
      logic             wr;
      logic             ph_end;

      assign wr     = cfg_we && ch_ok && (cfg_ch == CW'(i));
      // A half-period of zero behaves as one tick.
      assign h_last = (hval_q == '0) ? '0 : hval_q - VAL_W'(1);
      assign ph_end = (ph_q == h_last);

      always_ff @(posedge clk) begin
         if (rst) begin
            mode_q <= M_OFF;
            bst_q  <= B_IDLE;
            hval_q <= '0;
            ph_q   <= '0;
            duty_q <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            mode_q <= mode_d;
            bst_q  <= bst_d;
            hval_q <= hval_d;
            ph_q   <= ph_d;
            duty_q <= duty_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
         end
      end

      always_comb begin
         mode_d = mode_q;
         bst_d  = bst_q;
         hval_d = hval_q;
         ph_d   = ph_q;
         duty_d = duty_q;
         rem_d  = rem_q;
         led_d  = led_q;
         busy_d = busy_q;
         done_d = 1'b0;
         if (wr) begin
            mode_d = wr_mode;
            bst_d  = B_IDLE;
            hval_d = cfg_val;
            ph_d   = '0;
            duty_d = cfg_val[PWM_W-1:0];
            rem_d  = cfg_cnt;
            busy_d = 1'b0;
            unique case (wr_mode)
               M_ON:    led_d = 1'b1;
               M_BLINK: led_d = 1'b1;
               M_PWM:   led_d = wr_pwm_on;
               M_BURST: begin
                  if (cfg_cnt == 8'd0) begin
                     mode_d = M_OFF;
                     led_d  = 1'b0;
                     done_d = 1'b1;
                  end else begin
                     bst_d  = B_ON;
                     led_d  = 1'b1;
                     busy_d = 1'b1;
                  end
               end
               default: led_d = 1'b0;
            endcase
         end else begin
            unique case (mode_q)
               M_BLINK: begin
                  if (tick) begin
                     if (ph_end) begin
                        ph_d  = '0;
                        led_d = ~led_q;
                     end else begin
                        ph_d = ph_q + VAL_W'(1);
                     end
                  end
               end
               M_PWM: led_d = (pwm_q < duty_q);
               M_BURST: begin
                  if (tick) begin
                     if (!ph_end) begin
                        ph_d = ph_q + VAL_W'(1);
                     end else begin
                        ph_d = '0;
                        unique case (bst_q)
                           B_ON: begin
                              bst_d = B_OFF;
                              led_d = 1'b0;
                           end
                           B_OFF: begin
                              rem_d = rem_q - 8'd1;
                              if (rem_q > 8'd1) begin
                                 bst_d = B_ON;
                                 led_d = 1'b1;
                              end else begin
                                 bst_d  = B_IDLE;
                                 mode_d = M_OFF;
                                 busy_d = 1'b0;
                                 done_d = 1'b1;
                              end
                           end
                           default: begin
                              bst_d  = B_IDLE;
                              mode_d = M_OFF;
                              led_d  = 1'b0;
                              busy_d = 1'b0;
                           end
                        endcase
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      assign led[i]  = led_q;
      assign busy[i] = busy_q;
      assign done[i] = done_q;
   end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: scoreboarded bench; stimulus queues expected output
// changes and probes, a negedge monitor pops and compares them.
module tb_led_ctrl;

   localparam int CH      = 2;
   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int VAL_W   = 16;
   localparam int PWM_W   = 8;
   localparam int CW      = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_we = 1'b0;
   logic [CW-1:0]    cfg_ch = '0;
   logic [2:0]       cfg_mode = '0;
   logic [VAL_W-1:0] cfg_val = '0;
   logic [7:0]       cfg_cnt = '0;
   logic [CH-1:0]    led, busy, done;

   logic       we3 = 1'b0;
   logic [1:0] ch3 = '0;
   logic [2:0] led3, busy3, done3;

   always #5 clk = ~clk;

   led_ctrl #(
      .CH(CH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
      .VAL_W(VAL_W), .PWM_W(PWM_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_mode(cfg_mode), .cfg_val(cfg_val), .cfg_cnt(cfg_cnt),
      .led(led), .busy(busy), .done(done)
   );

   led_ctrl #(
      .CH(3), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
      .VAL_W(VAL_W), .PWM_W(PWM_W)
   ) dut3 (
      .clk(clk), .rst(rst), .cfg_we(we3), .cfg_ch(ch3),
      .cfg_mode(cfg_mode), .cfg_val(cfg_val), .cfg_cnt(cfg_cnt),
      .led(led3), .busy(busy3), .done(done3)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int t_wr  = 0;
   int t_evt = 0;
   bit mon_en = 1'b0;
   logic [5:0] prev = '0;

   logic [5:0] ev_v[$];
   int         ev_g[$];
   string      pr_n[$];
   int         pr_a[$];
   int         pr_e[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Output vector is {done, busy, led}; gap -1 means timing is free.
   always @(negedge clk) begin
      logic [5:0] cur;
      logic [5:0] ev;
      int         g;
      int         rt;
      string      n;
      int         a;
      int         e;
      cur = {done, busy, led};
      while (pr_n.size() > 0) begin
         n = pr_n.pop_front();
         a = pr_a.pop_front();
         e = pr_e.pop_front();
         tests++;
         if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", n, a, e);
         end
      end
      if (mon_en && cur !== prev) begin
         rt = (t_wr > t_evt) ? t_wr : t_evt;
         tests++;
         if (ev_v.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: got %b at cycle %0d, required no change",
                     cur, cyc);
         end else begin
            ev = ev_v.pop_front();
            g  = ev_g.pop_front();
            if (cur !== ev || (g >= 0 && cyc - rt != g)) begin
               fails++;
               $display("FAIL event: got %b after %0d cycles, required %b after %0d",
                        cur, cyc - rt, ev, g);
            end
         end
         t_evt = cyc;
      end
      prev = cur;
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(logic [5:0] v, int g);
      ev_v.push_back(v);
      ev_g.push_back(g);
   endtask

   task automatic probe(string n, int a, int e);
      pr_n.push_back(n);
      pr_a.push_back(a);
      pr_e.push_back(e);
   endtask

   task automatic wr(int ch, int mode, int val, int cnt);
      cfg_we   = 1'b1;
      cfg_ch   = CW'(ch);
      cfg_mode = 3'(mode);
      cfg_val  = VAL_W'(val);
      cfg_cnt  = 8'(cnt);
      @(posedge clk);
      #1;
      t_wr   = cyc;
      cfg_we = 1'b0;
   endtask

   task automatic drain(string n, int budget);
      int k;
      k = 0;
      while (ev_v.size() != 0 && k < budget) begin
         step(1);
         k++;
      end
      probe(n, ev_v.size(), 0);
   endtask

   task automatic pwm_window(int duty);
      int hi;
      int oth;
      wr(1, 3, duty, 0);
      step(2);
      hi  = 0;
      oth = 0;
      for (int i = 0; i < 256; i++) begin
         if (led[1]) hi++;
         if ({done, busy, led[0]} != 3'b000) oth++;
         step(1);
      end
      probe("pwm_high_count", hi, (duty == 255) ? 255 : duty);
      probe("pwm_other_bits", oth, 0);
   endtask

   initial begin
      int k;
      int n;
      step(3);
      rst  = 1'b0;
      t_wr = cyc;
      probe("reset_outputs", int'({done, busy, led}), 0);
      probe("reset_outputs_ch3", int'({done3, busy3, led3}), 0);
      mon_en = 1'b1;

      for (int r = 0; r < 3; r++) begin
         k = 0;
         while (dut.tick !== 1'b1 && k < 20) begin
            step(1);
            k++;
         end
         n = 0;
         do begin
            step(1);
            n++;
         end while (dut.tick !== 1'b1 && n < 20);
         probe("tick_period", n, 10);
      end
      step(70);
      probe("idle_outputs", int'({done, busy, led}), 0);

      expect_ev(6'b000001, 0);
      expect_ev(6'b000000, -1);
      expect_ev(6'b000001, 30);
      expect_ev(6'b000000, 30);
      wr(0, 2, 3, 0);
      drain("blink_drain", 150);
      mon_en = 1'b0;
      wr(0, 0, 0, 0);
      step(2);
      probe("blink_off", int'({done, busy, led}), 0);
      mon_en = 1'b1;

      mon_en = 1'b0;
      pwm_window(64);
      pwm_window(0);
      pwm_window(255);
      wr(1, 0, 0, 0);
      step(2);
      probe("pwm_off", int'({done, busy, led}), 0);
      mon_en = 1'b1;

      expect_ev(6'b000101, 0);
      expect_ev(6'b000100, -1);
      expect_ev(6'b000101, 20);
      expect_ev(6'b000100, 20);
      expect_ev(6'b000101, 20);
      expect_ev(6'b000100, 20);
      expect_ev(6'b010000, 20);
      expect_ev(6'b000000, 1);
      wr(0, 4, 2, 3);
      drain("burst_drain", 200);
      step(50);
      probe("burst_after", int'({done, busy, led}), 0);

      expect_ev(6'b010000, 0);
      expect_ev(6'b000000, 1);
      wr(0, 4, 2, 0);
      drain("burst0_drain", 10);

      we3 = 1'b1;
      ch3 = 2'd3;
      cfg_mode = 3'd1;
      step(1);
      we3 = 1'b0;
      step(1);
      probe("bad_channel", int'({done3, busy3, led3}), 0);
      we3 = 1'b1;
      ch3 = 2'd2;
      step(1);
      we3 = 1'b0;
      step(1);
      probe("ch3_valid_write", int'(led3), 4);

      mon_en = 1'b0;
      wr(0, 4, 2, 3);
      step(25);
      expect_ev(6'b000001, 0);
      wr(0, 1, 0, 0);
      mon_en = 1'b1;
      step(60);
      drain("abort_drain", 5);
      probe("abort_state", int'({done, busy, led}), 1);

      expect_ev(6'b000101, 0);
      wr(0, 4, 2, 3);
      step(5);
      expect_ev(6'b000000, 0);
      rst      = 1'b1;
      cfg_we   = 1'b1;
      cfg_ch   = 1'b1;
      cfg_mode = 3'd1;
      @(posedge clk);
      #1;
      t_wr   = cyc;
      rst    = 1'b0;
      cfg_we = 1'b0;
      step(30);
      drain("reset_drain", 5);
      probe("reset_mid_burst", int'({done, busy, led}), 0);

      step(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

endmodule
